// File: rtl/eater_pkg.sv
// Shared definitions for the 8-bit bus machine: opcodes, control-word layout
// and sequencer run states.
package eater_pkg;

    localparam int unsigned STEPS_DEF = 5;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned CW_W      = 16;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // Control-word bit positions
    localparam int unsigned CW_HLT = 15;
    localparam int unsigned CW_MI  = 14;
    localparam int unsigned CW_RI  = 13;
    localparam int unsigned CW_RO  = 12;
    localparam int unsigned CW_IO  = 11;
    localparam int unsigned CW_II  = 10;
    localparam int unsigned CW_AI  = 9;
    localparam int unsigned CW_AO  = 8;
    localparam int unsigned CW_EO  = 7;
    localparam int unsigned CW_SU  = 6;
    localparam int unsigned CW_BI  = 5;
    localparam int unsigned CW_OI  = 4;
    localparam int unsigned CW_CE  = 3;
    localparam int unsigned CW_CO  = 2;
    localparam int unsigned CW_J   = 1;
    localparam int unsigned CW_FI  = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    typedef enum logic {
        RUN_ST  = 1'b0,
        HALT_ST = 1'b1
    } run_state_t;

    function automatic ctrl_word_t cw_bit(input int unsigned idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word, plus a flag
// marking the instruction's last active step.
module microcode_rom
    import eater_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              flag_c,
    input  logic              flag_z,
    output ctrl_word_t        ctrl,
    output logic              last_step
);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        case (step)
            3'd0: ctrl = cw_bit(CW_CO) | cw_bit(CW_MI);
            3'd1: ctrl = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
            3'd2: begin
                // Single-step instructions (and NOPs / untaken jumps) end here
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl      = cw_bit(CW_IO) | cw_bit(CW_MI);
                        last_step = 1'b0;
                    end
                    OP_LDI: ctrl = cw_bit(CW_IO) | cw_bit(CW_AI);
                    OP_JMP: ctrl = cw_bit(CW_IO) | cw_bit(CW_J);
                    OP_JC:  ctrl = flag_c ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                    OP_JZ:  ctrl = flag_z ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                    OP_OUT: ctrl = cw_bit(CW_AO) | cw_bit(CW_OI);
                    OP_HLT: ctrl = cw_bit(CW_HLT);
                    default: ctrl = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl      = cw_bit(CW_RO) | cw_bit(CW_AI);
                        last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: ctrl = cw_bit(CW_RO) | cw_bit(CW_BI);
                    OP_STA: begin
                        ctrl      = cw_bit(CW_AO) | cw_bit(CW_RI);
                        last_step = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD: begin
                        ctrl      = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                        last_step = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl      = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_SU)
                                  | cw_bit(CW_FI);
                        last_step = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer and halt latch for the 8-bit bus machine; control word is
// decoded combinationally and valid for the whole step.
module control_sequencer
    import eater_pkg::*;
#(
    parameter int unsigned STEPS     = STEPS_DEF,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [OP_W-1:0]   opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic              hlt,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              ii,
    output logic              io,
    output logic              ai,
    output logic              ao,
    output logic              eo,
    output logic              su,
    output logic              bi,
    output logic              oi,
    output logic              ce,
    output logic              co,
    output logic              j,
    output logic              fi,
    output logic [STEP_W-1:0] t_state
);

    localparam logic [STEP_W-1:0] LAST_T = STEP_W'(STEPS - 1);

    logic [STEP_W-1:0] step_q;
    run_state_t        run_q;
    ctrl_word_t        rom_word;
    ctrl_word_t        ctrl_c;
    logic              rom_last;
    logic              halt_req;

    microcode_rom u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .ctrl      (rom_word),
        .last_step (rom_last)
    );

    // HLT is only decoded at T2, so the counter is already parked on 2
    assign halt_req = rom_word[CW_HLT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            run_q  <= RUN_ST;
        end else if (en && (run_q == RUN_ST)) begin
            if (halt_req) begin
                run_q <= HALT_ST;
            end else if ((step_q == LAST_T) || (EARLY_END && rom_last)) begin
                step_q <= '0;
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

    // Reset gating and halt override of the decoded word
    always_comb begin
        ctrl_c = rom_word;
        if (!rst_n) begin
            ctrl_c = '0;
        end else if (run_q == HALT_ST) begin
            ctrl_c = cw_bit(CW_HLT);
        end
    end

    assign hlt     = ctrl_c[CW_HLT];
    assign mi      = ctrl_c[CW_MI];
    assign ri      = ctrl_c[CW_RI];
    assign ro      = ctrl_c[CW_RO];
    assign ii      = ctrl_c[CW_II];
    assign io      = ctrl_c[CW_IO];
    assign ai      = ctrl_c[CW_AI];
    assign ao      = ctrl_c[CW_AO];
    assign eo      = ctrl_c[CW_EO];
    assign su      = ctrl_c[CW_SU];
    assign bi      = ctrl_c[CW_BI];
    assign oi      = ctrl_c[CW_OI];
    assign ce      = ctrl_c[CW_CE];
    assign co      = ctrl_c[CW_CO];
    assign j       = ctrl_c[CW_J];
    assign fi      = ctrl_c[CW_FI];
    assign t_state = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table for the EARLY_END=1
// build, hand sequences for halt/reset, and a full-length build sweep.
module tb_control_sequencer;

    localparam logic [15:0] M_HLT = 16'h8000;
    localparam logic [15:0] M_MI  = 16'h4000;
    localparam logic [15:0] M_RI  = 16'h2000;
    localparam logic [15:0] M_RO  = 16'h1000;
    localparam logic [15:0] M_IO  = 16'h0800;
    localparam logic [15:0] M_II  = 16'h0400;
    localparam logic [15:0] M_AI  = 16'h0200;
    localparam logic [15:0] M_AO  = 16'h0100;
    localparam logic [15:0] M_EO  = 16'h0080;
    localparam logic [15:0] M_SU  = 16'h0040;
    localparam logic [15:0] M_BI  = 16'h0020;
    localparam logic [15:0] M_OI  = 16'h0010;
    localparam logic [15:0] M_CE  = 16'h0008;
    localparam logic [15:0] M_CO  = 16'h0004;
    localparam logic [15:0] M_J   = 16'h0002;
    localparam logic [15:0] M_FI  = 16'h0001;

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        logic        en;
        logic [2:0]  t;
        logic [15:0] w;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // EARLY_END=1 instance
    logic       rst_n, en, fc, fz;
    logic [3:0] op;
    logic       hlt, mi, ri, ro, ii, io, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic [2:0] t_state;
    logic [15:0] w1;

    // EARLY_END=0 instance
    logic       rst0_n, en0, fc0, fz0;
    logic [3:0] op0;
    logic       hlt0, mi0, ri0, ro0, ii0, io0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0;
    logic [2:0] t_state0;
    logic [15:0] w0;

    assign w1 = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};
    assign w0 = {hlt0, mi0, ri0, ro0, io0, ii0, ai0, ao0, eo0, su0, bi0, oi0, ce0, co0, j0, fi0};

    control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(op), .flag_c(fc), .flag_z(fz),
        .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .ii(ii), .io(io), .ai(ai), .ao(ao),
        .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
        .t_state(t_state)
    );

    control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .en(en0), .opcode(op0), .flag_c(fc0), .flag_z(fz0),
        .hlt(hlt0), .mi(mi0), .ri(ri0), .ro(ro0), .ii(ii0), .io(io0), .ai(ai0), .ao(ao0),
        .eo(eo0), .su(su0), .bi(bi0), .oi(oi0), .ce(ce0), .co(co0), .j(j0), .fi(fi0),
        .t_state(t_state0)
    );

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [2:0] exp_t, input logic [15:0] exp_w);
        checks++;
        if (t_state !== exp_t || w1 !== exp_w) begin
            errors++;
            $display("FAIL %s: t_state=%0d word=%04h, want t_state=%0d word=%04h",
                     name, t_state, w1, exp_t, exp_w);
        end
    endtask

    task automatic chk0(input string name, input logic [2:0] exp_t, input logic [15:0] exp_w);
        checks++;
        if (t_state0 !== exp_t || w0 !== exp_w) begin
            errors++;
            $display("FAIL %s: t_state=%0d word=%04h, want t_state=%0d word=%04h",
                     name, t_state0, w0, exp_t, exp_w);
        end
    endtask

    task automatic push(input logic [3:0] o, input logic c, input logic z, input logic e,
                        input logic [2:0] t, input logic [15:0] w);
        vec_t v;
        v.op = o; v.fc = c; v.fz = z; v.en = e; v.t = t; v.w = w;
        vecs.push_back(v);
    endtask

    task automatic fetch(input logic [3:0] o, input logic c, input logic z);
        push(o, c, z, 1'b1, 3'd0, M_CO | M_MI);
        push(o, c, z, 1'b1, 3'd1, M_RO | M_II | M_CE);
    endtask

    initial begin
        // ---- instruction table for the EARLY_END=1 build ----
        fetch(4'h5, 0, 0); push(4'h5, 0, 0, 1, 2, M_IO | M_AI);                    // LDI
        fetch(4'h1, 0, 0); push(4'h1, 0, 0, 1, 2, M_IO | M_MI);                    // LDA
                           push(4'h1, 0, 0, 1, 3, M_RO | M_AI);
        fetch(4'h2, 0, 0); push(4'h2, 0, 0, 1, 2, M_IO | M_MI);                    // ADD
                           push(4'h2, 0, 0, 1, 3, M_RO | M_BI);
                           push(4'h2, 0, 0, 1, 4, M_EO | M_AI | M_FI);
        fetch(4'h3, 1, 1); push(4'h3, 1, 1, 1, 2, M_IO | M_MI);                    // SUB
                           push(4'h3, 1, 1, 1, 3, M_RO | M_BI);
                           push(4'h3, 1, 1, 1, 4, M_EO | M_AI | M_SU | M_FI);
        fetch(4'h4, 0, 0); push(4'h4, 0, 0, 1, 2, M_IO | M_MI);                    // STA, paused at T3
        for (int i = 0; i < 4; i++) push(4'h4, 0, 0, 0, 3, M_AO | M_RI);
                           push(4'h4, 0, 0, 1, 3, M_AO | M_RI);
        fetch(4'h6, 0, 0); push(4'h6, 0, 0, 1, 2, M_IO | M_J);                     // JMP
        fetch(4'h8, 0, 1); push(4'h8, 0, 1, 1, 2, M_IO | M_J);                     // JZ taken
        fetch(4'h8, 1, 0); push(4'h8, 1, 0, 1, 2, 16'h0000);                       // JZ not taken
        fetch(4'h7, 1, 0); push(4'h7, 1, 0, 1, 2, M_IO | M_J);                     // JC taken
        fetch(4'h7, 0, 1); push(4'h7, 0, 1, 1, 2, 16'h0000);                       // JC not taken
        fetch(4'h8, 0, 0); push(4'h8, 0, 1, 1, 2, M_IO | M_J);                     // flag only at T2
        fetch(4'hE, 0, 0); push(4'hE, 0, 0, 1, 2, M_AO | M_OI);                    // OUT
        fetch(4'h0, 0, 0); push(4'h0, 0, 0, 1, 2, 16'h0000);                       // NOP
        fetch(4'hB, 1, 1); push(4'hB, 1, 1, 1, 2, 16'h0000);                       // unused opcode

        rst_n = 1'b0; en = 1'b1; op = 4'h5; fc = 1'b0; fz = 1'b0;
        rst0_n = 1'b0; en0 = 1'b1; op0 = 4'h5; fc0 = 1'b0; fz0 = 1'b0;

        // ---- reset state ----
        @(negedge clk); @(negedge clk); #1;
        chk("reset", 3'd0, 16'h0000);
        checks++;
        if (w0 !== 16'h0000 || t_state0 !== 3'd0) begin
            errors++;
            $display("FAIL reset0: t_state=%0d word=%04h, want 0/0000", t_state0, w0);
        end

        // ---- table run ----
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[k]) begin
            if (k != 0) @(negedge clk);
            op = vecs[k].op; fc = vecs[k].fc; fz = vecs[k].fz; en = vecs[k].en;
            #1;
            chk($sformatf("vec%0d", k), vecs[k].t, vecs[k].w);
        end

        // ---- halt: en=0 at T2 must not latch ----
        en = 1'b1; fc = 1'b0; fz = 1'b0;
        @(negedge clk); op = 4'hF; #1; chk("hlt_t0", 3'd0, M_CO | M_MI);
        @(negedge clk); #1; chk("hlt_t1", 3'd1, M_RO | M_II | M_CE);
        @(negedge clk); en = 1'b0; #1; chk("hlt_t2_paused", 3'd2, M_HLT);
        @(negedge clk); #1; chk("hlt_t2_paused2", 3'd2, M_HLT);
        @(negedge clk); op = 4'h5; #1; chk("hlt_not_latched", 3'd2, M_IO | M_AI);
        @(negedge clk); op = 4'hF; en = 1'b1; #1; chk("hlt_t2", 3'd2, M_HLT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en = 1'(i % 2);
            op = 4'(i);
            #1;
            chk($sformatf("halted%0d", i), 3'd2, M_HLT);
        end

        // ---- leave halt via reset ----
        @(negedge clk); rst_n = 1'b0; #1; chk("hlt_reset", 3'd0, 16'h0000);
        @(negedge clk); rst_n = 1'b1; en = 1'b1; op = 4'h5; #1;
        chk("post_hlt_t0", 3'd0, M_CO | M_MI);
        @(negedge clk); #1; chk("post_hlt_t1", 3'd1, M_RO | M_II | M_CE);
        @(negedge clk); #1; chk("post_hlt_t2", 3'd2, M_IO | M_AI);
        @(negedge clk); #1; chk("post_hlt_wrap", 3'd0, M_CO | M_MI);

        // ---- asynchronous reset mid-instruction ----
        op = 4'h2;
        @(negedge clk); #1; chk("abort_t1", 3'd1, M_RO | M_II | M_CE);
        @(negedge clk); #1; chk("abort_t2", 3'd2, M_IO | M_MI);
        @(negedge clk); #1; chk("abort_t3", 3'd3, M_RO | M_BI);
        #2 rst_n = 1'b0; #1; chk("abort_async", 3'd0, 16'h0000);
        @(negedge clk); rst_n = 1'b1; #1; chk("abort_refetch", 3'd0, M_CO | M_MI);

        // ---- EARLY_END=0: LDI runs all five steps ----
        @(negedge clk); rst0_n = 1'b1; op0 = 4'h5; #1;
        chk0("full_t0", 3'd0, M_CO | M_MI);
        @(negedge clk); #1; chk0("full_t1", 3'd1, M_RO | M_II | M_CE);
        @(negedge clk); #1; chk0("full_t2", 3'd2, M_IO | M_AI);
        @(negedge clk); #1; chk0("full_t3", 3'd3, 16'h0000);
        @(negedge clk); #1; chk0("full_t4", 3'd4, 16'h0000);

        // ---- EARLY_END=0 sweep: fixed 5-step cadence, never ri with ro ----
        for (int n = 0; n < 1000; n++) begin
            logic [3:0] opc;
            opc = 4'($urandom_range(0, 14));
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                op0 = opc;
                fc0 = 1'($urandom);
                fz0 = 1'($urandom);
                #1;
                checks++;
                if (t_state0 !== 3'(s) || (ri0 && ro0)) begin
                    errors++;
                    $display("FAIL sweep n=%0d op=%0h: t_state=%0d ri=%0b ro=%0b, want t_state=%0d not both",
                             n, opc, t_state0, ri0, ro0, s);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
